// File: rtl/lamb5_seq_scheduler_pkg.sv
// Shared definitions for the 5-lamp sequence scheduler: state and mode codes,
// table size and the lamp pattern decode.
package lamb5_seq_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] M_FWD = 2'd0;
  localparam logic [1:0] M_REV = 2'd1;
  localparam logic [1:0] M_PP  = 2'd2;

  localparam int         LAMB_NUM = 6;
  localparam logic [2:0] IDX_LAST = 3'(LAMB_NUM - 1);

  localparam logic [4:0] PAT0 = 5'b00000;
  localparam logic [4:0] PAT1 = 5'b11111;
  localparam logic [4:0] PAT2 = 5'b10101;
  localparam logic [4:0] PAT3 = 5'b10001;
  localparam logic [4:0] PAT4 = 5'b10011;
  localparam logic [4:0] PAT5 = 5'b10010;

  // Indices 6 and 7 are unreachable; they decode to all lamps off.
  function automatic logic [4:0] pat_decode(input logic [2:0] idx);
    logic [4:0] pat;
    case (idx)
      3'd0:    pat = PAT0;
      3'd1:    pat = PAT1;
      3'd2:    pat = PAT2;
      3'd3:    pat = PAT3;
      3'd4:    pat = PAT4;
      3'd5:    pat = PAT5;
      default: pat = 5'b00000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/lamb5_seq_scheduler_step_divider.sv
// Step-rate prescaler: counts 0..period while enabled and flags the terminal count.
module lamb5_step_divider #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_term;

  // The counter wraps at the terminal value, so it never exceeds i_period.
  assign w_term = (r_cnt == i_period);
  assign o_tick = w_term;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lamb5_seq_scheduler.sv
// Run-time scheduler for the 5-lamp display: sequences the pattern table forward,
// reverse or ping-pong for a programmed number of loops, with pause and abort.
module lamb5_seq_scheduler
  import lamb5_seq_scheduler_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             trigger,
  input  logic             sysRst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] repeatCnt,
  output logic             busy,
  output logic             done,
  output logic             stepPulse,
  output logic [2:0]       patIndex,
  output logic [4:0]       lamb,
  output logic [CNT_W-1:0] loopsLeft
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_period;
  logic [CNT_W-1:0] r_loops;
  logic [2:0]       r_idx;
  logic             r_dir_up;
  logic             r_done;

  logic             w_active;
  logic             w_start_ok;
  logic             w_abort;
  logic             w_run_en;
  logic             w_tick;
  logic             w_step;
  logic             w_loop_end;
  logic             w_last_loop;
  logic [2:0]       w_idx_adv;
  logic             w_dir_adv;
  logic [1:0]       w_mode_norm;

  assign w_active    = (r_state != S_IDLE);
  assign w_start_ok  = !sysRst && (r_state == S_IDLE) && start && !stop;
  assign w_abort     = w_active && stop;
  assign w_run_en    = !sysRst && (r_state == S_RUN) && !stop && !pause;
  assign w_step      = w_run_en && w_tick;
  assign w_last_loop = (r_loops == CNT_W'(1));
  assign w_mode_norm = (mode == M_REV || mode == M_PP) ? mode : M_FWD;

  lamb5_step_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .i_clk    (trigger),
    .i_rst    (sysRst),
    .i_clr    (w_start_ok || w_abort),
    .i_en     (w_run_en),
    .i_period (r_period),
    .o_tick   (w_tick)
  );

  // Next index/direction and loop-boundary detection for the latched mode.
  always_comb begin
    w_idx_adv  = r_idx;
    w_dir_adv  = r_dir_up;
    w_loop_end = 1'b0;
    case (r_mode)
      M_REV: begin
        w_idx_adv  = (r_idx == 3'd0) ? IDX_LAST : r_idx - 3'd1;
        w_loop_end = (r_idx == 3'd0);
      end
      M_PP: begin
        if (r_dir_up) begin
          w_idx_adv = r_idx + 3'd1;
          w_dir_adv = (r_idx != IDX_LAST - 3'd1);
        end else begin
          w_idx_adv  = r_idx - 3'd1;
          w_dir_adv  = (r_idx == 3'd1);
          w_loop_end = (r_idx == 3'd1);
        end
      end
      default: begin
        w_idx_adv  = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        w_loop_end = (r_idx == IDX_LAST);
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_state_nxt = pause ? S_HOLD : S_RUN;
      end
      S_RUN: begin
        if (stop)                                    w_state_nxt = S_IDLE;
        else if (pause)                              w_state_nxt = S_HOLD;
        else if (w_step && w_loop_end && w_last_loop) w_state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (stop)        w_state_nxt = S_IDLE;
        else if (!pause) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge trigger) begin
    if (sysRst) begin
      r_state  <= S_IDLE;
      r_mode   <= M_FWD;
      r_period <= '0;
      r_loops  <= '0;
      r_idx    <= 3'd0;
      r_dir_up <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_start_ok) begin
        r_mode   <= w_mode_norm;
        r_period <= period;
        r_loops  <= repeatCnt;
        r_idx    <= (w_mode_norm == M_REV) ? IDX_LAST : 3'd0;
        r_dir_up <= 1'b1;
      end else if (w_abort) begin
        r_idx    <= 3'd0;
        r_loops  <= '0;
        r_dir_up <= 1'b1;
      end else if (w_step) begin
        if (w_loop_end && w_last_loop) begin
          r_idx    <= 3'd0;
          r_loops  <= '0;
          r_dir_up <= 1'b1;
          r_done   <= 1'b1;
        end else begin
          r_idx    <= w_idx_adv;
          r_dir_up <= w_dir_adv;
          // A zero loop count means run until stopped, so it never decrements.
          if (w_loop_end && (r_loops > CNT_W'(1))) r_loops <= r_loops - CNT_W'(1);
        end
      end
    end
  end

  assign busy      = w_active;
  assign done      = r_done;
  assign stepPulse = w_step;
  assign patIndex  = r_idx;
  assign lamb      = pat_decode(r_idx);
  assign loopsLeft = r_loops;

endmodule

// File: tb/tb_lamb5_seq_scheduler.sv
// Bench for lamb5_seq_scheduler: directed scenarios with literal expectations plus
// randomized command traffic checked every cycle against a sequence-position model.
module tb_lamb5_seq_scheduler;

  localparam int DIV_W = 16;
  localparam int CNT_W = 8;

  logic             trigger = 1'b0;
  logic             sysRst  = 1'b1;
  logic             start   = 1'b0;
  logic             stop    = 1'b0;
  logic             pause   = 1'b0;
  logic [1:0]       mode    = 2'd0;
  logic [DIV_W-1:0] period  = '0;
  logic [CNT_W-1:0] repeatCnt = '0;
  logic             busy, done, stepPulse;
  logic [2:0]       patIndex;
  logic [4:0]       lamb;
  logic [CNT_W-1:0] loopsLeft;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 trigger = ~trigger;

  lamb5_seq_scheduler #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .trigger   (trigger),
    .sysRst    (sysRst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .period    (period),
    .repeatCnt (repeatCnt),
    .busy      (busy),
    .done      (done),
    .stepPulse (stepPulse),
    .patIndex  (patIndex),
    .lamb      (lamb),
    .loopsLeft (loopsLeft)
  );

  logic [4:0] PAT [6] = '{5'b00000, 5'b11111, 5'b10101, 5'b10001, 5'b10011, 5'b10010};

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a run walks a fixed per-mode index sequence; a loop is one pass through it.
  int m_ph = 0;             // 0 idle, 1 running, 2 held
  int m_seq [10];
  int m_len = 6;
  int m_pos = 0;
  int m_wait = 0;
  int m_per = 0;
  int m_loops = 0;
  bit m_done = 1'b0;
  bit m_live = 1'b0;

  always @(posedge trigger) begin
    m_done = 1'b0;
    if (sysRst) begin
      m_ph = 0; m_pos = 0; m_wait = 0; m_loops = 0; m_live = 1'b1;
    end else if (m_ph != 0 && stop) begin
      m_ph = 0; m_loops = 0;
    end else if (m_ph == 0) begin
      if (start && !stop) begin
        if (mode == 2'd1) begin
          m_len = 6;
          for (int i = 0; i < 6; i++) m_seq[i] = 5 - i;
        end else if (mode == 2'd2) begin
          m_len = 10;
          for (int i = 0; i < 10; i++) m_seq[i] = (i <= 5) ? i : 10 - i;
        end else begin
          m_len = 6;
          for (int i = 0; i < 6; i++) m_seq[i] = i;
        end
        m_per = int'(period);
        m_loops = int'(repeatCnt);
        m_pos = 0; m_wait = 0;
        m_ph = pause ? 2 : 1;
      end
    end else if (m_ph == 2) begin
      if (!pause) m_ph = 1;
    end else begin
      if (pause) m_ph = 2;
      else if (m_wait == m_per) begin
        m_wait = 0;
        m_pos = m_pos + 1;
        if (m_pos == m_len) begin
          m_pos = 0;
          if (m_loops == 1) begin
            m_ph = 0; m_loops = 0; m_done = 1'b1;
          end else if (m_loops > 1) begin
            m_loops = m_loops - 1;
          end
        end
      end else begin
        m_wait = m_wait + 1;
      end
    end
  end

  always @(negedge trigger) begin
    if (m_live) begin
      int e_idx;
      bit e_step;
      e_idx  = (m_ph == 0) ? 0 : m_seq[m_pos];
      e_step = (m_ph == 1) && !stop && !pause && !sysRst && (m_wait == m_per);
      chk("busy",      32'(busy),      32'(m_ph != 0));
      chk("done",      32'(done),      32'(m_done));
      chk("stepPulse", 32'(stepPulse), 32'(e_step));
      chk("patIndex",  32'(patIndex),  32'(e_idx));
      chk("lamb",      32'(lamb),      32'(PAT[e_idx]));
      chk("loopsLeft", 32'(loopsLeft), 32'(m_loops));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge trigger);
      #1;
    end
  endtask

  int q_idx [$];
  int q_cyc [$];
  bit d_seen;
  int d_cyc, d_idx, d_busy;

  task automatic collect(input int budget);
    q_idx.delete(); q_cyc.delete();
    d_seen = 1'b0; d_cyc = -1; d_idx = -1; d_busy = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge trigger);
      if (stepPulse === 1'b1) begin
        q_idx.push_back(int'(patIndex));
        q_cyc.push_back(c);
      end
      if (done === 1'b1) begin
        d_seen = 1'b1; d_cyc = c; d_idx = int'(patIndex); d_busy = int'(busy);
        break;
      end
    end
    @(posedge trigger);
    #1;
  endtask

  task automatic launch(input logic [1:0] md, input int per, input int rc, input logic pz);
    mode = md; period = DIV_W'(per); repeatCnt = CNT_W'(rc); pause = pz; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int pp_exp [10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};
    logic [2:0] held_idx;

    sysRst = 1'b1;
    tick(2);
    sysRst = 1'b0;
    @(negedge trigger);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx",  32'(patIndex), 32'd0);
    chk("rst_lamb", 32'(lamb), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick(1);

    // Forward, every cycle, single loop.
    launch(2'd0, 0, 1, 1'b0);
    collect(40);
    chk("fwd_steps", 32'(q_idx.size()), 32'd6);
    for (int i = 0; i < q_idx.size() && i < 6; i++) begin
      chk("fwd_idx", 32'(q_idx[i]), 32'(i));
      chk("fwd_cyc", 32'(q_cyc[i]), 32'(i));
    end
    chk("fwd_done_seen", 32'(d_seen), 32'd1);
    chk("fwd_done_cyc",  32'(d_cyc),  32'd6);
    chk("fwd_done_idx",  32'(d_idx),  32'd0);
    chk("fwd_done_busy", 32'(d_busy), 32'd0);
    tick(2);

    // Reverse, period 2, two loops.
    launch(2'd1, 2, 2, 1'b0);
    mode = 2'd0; period = 16'd7; repeatCnt = 8'd9;
    @(negedge trigger);
    chk("rev_loops0", 32'(loopsLeft), 32'd2);
    chk("rev_idx0",   32'(patIndex),  32'd5);
    tick(1);
    collect(200);
    chk("rev_steps", 32'(q_idx.size()), 32'd12);
    for (int i = 0; i < q_idx.size() && i < 12; i++) begin
      chk("rev_idx", 32'(q_idx[i]), 32'(5 - (i % 6)));
      chk("rev_cyc", 32'(q_cyc[i]), 32'(1 + 3 * i));
    end
    chk("rev_done_seen", 32'(d_seen), 32'd1);
    chk("rev_loops_end", 32'(loopsLeft), 32'd0);
    tick(2);

    // Ping-pong, every cycle, single loop.
    launch(2'd2, 0, 1, 1'b0);
    collect(60);
    chk("pp_steps", 32'(q_idx.size()), 32'd10);
    for (int i = 0; i < q_idx.size() && i < 10; i++)
      chk("pp_idx", 32'(q_idx[i]), 32'(pp_exp[i]));
    chk("pp_done_seen", 32'(d_seen), 32'd1);
    chk("pp_done_cyc",  32'(d_cyc),  32'd10);
    tick(2);

    // Pause mid-run freezes the index; spacing afterwards is unchanged.
    launch(2'd0, 2, 0, 1'b0);
    tick(7);
    pause = 1'b1;
    held_idx = patIndex;
    tick(4);
    @(negedge trigger);
    chk("pause_idx",  32'(patIndex),  32'(held_idx));
    chk("pause_step", 32'(stepPulse), 32'd0);
    tick(1);
    pause = 1'b0;
    collect(14);
    chk("resume_steps", 32'(q_cyc.size() >= 3), 32'd1);
    for (int i = 1; i < q_cyc.size(); i++)
      chk("resume_gap", 32'(q_cyc[i] - q_cyc[i-1]), 32'd3);

    // Stop and pause together abort to idle without done.
    stop = 1'b1; pause = 1'b1;
    tick(1);
    stop = 1'b0; pause = 1'b0;
    @(negedge trigger);
    chk("stop_busy",  32'(busy), 32'd0);
    chk("stop_done",  32'(done), 32'd0);
    chk("stop_idx",   32'(patIndex), 32'd0);
    tick(2);

    // Infinite run spans several loops, then reset clears it.
    launch(2'd0, 0, 0, 1'b0);
    collect(25);
    chk("inf_steps", 32'(q_idx.size()), 32'd25);
    chk("inf_nodone", 32'(d_seen), 32'd0);
    chk("inf_busy", 32'(busy), 32'd1);
    sysRst = 1'b1;
    tick(1);
    sysRst = 1'b0;
    @(negedge trigger);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_idx",  32'(patIndex), 32'd0);
    chk("mrst_lamb", 32'(lamb), 32'd0);
    tick(1);

    // Start while paused goes straight to hold.
    launch(2'd1, 1, 3, 1'b1);
    @(negedge trigger);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_idx",  32'(patIndex), 32'd5);
    chk("hold_step", 32'(stepPulse), 32'd0);
    tick(3);
    pause = 1'b0;
    tick(20);

    // Randomized command traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      sysRst = ($urandom_range(0, 199) == 0);
      stop   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 14) == 0) pause = ~pause;
      start  = ($urandom_range(0, 5) == 0);
      mode   = 2'($urandom_range(0, 3));
      period = ($urandom_range(0, 49) == 0) ? 16'hFFFF : DIV_W'($urandom_range(0, 3));
      repeatCnt = CNT_W'($urandom_range(0, 3));
      tick(1);
    end
    sysRst = 1'b0; stop = 1'b0; start = 1'b0; pause = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
